// File: rtl/rca32_acc_pkg.sv
// Shared constants and state encoding for the rca32 streaming accumulator.
package rca32_acc_pkg;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;
    localparam int CNT_W = LEN_W + 1;

    // A length field of zero stands for the full 2^LEN_W beats.
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(1 << LEN_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/rca32_acc_if.sv
// Control, operand-stream and result-stream signals of the accumulator.
// Handshake rule: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface rca32_acc_if;
    import rca32_acc_pkg::*;

    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;
    state_e           dbg_state;

    modport master (
        output start, cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy, dbg_state
    );

    modport slave (
        input  start, cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy, dbg_state
    );

endinterface

// File: rtl/rca32_acc_rca32.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module rca32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [32:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[32];

endmodule

// File: rtl/rca32_acc.sv
// Streaming block accumulator: sums a programmed number of beats through one rca32
// and presents the sum plus a sticky carry flag on a valid/ready result port.
module rca32_acc
    import rca32_acc_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    rca32_acc_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             beat;

    rca32 u_rca32 (
        .a  (acc_q),
        .b  (bus.in_data),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    assign beat = (state_q == ST_ACCUM) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = (bus.cfg_len == '0) ? LEN_MAX : {1'b0, bus.cfg_len};
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = add_s;
                    ovf_d = ovf_q | add_co;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // acc/ovf are frozen here, so the result stays stable under backpressure.
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rca32_acc.sv
// Self-checking bench for rca32_acc: scenario tasks, a 33-bit reference adder
// and an expected-result queue popped on each result handshake.
module tb_rca32_acc;
    import rca32_acc_pkg::*;

    logic clk;
    logic reset_n;

    rca32_acc_if bus ();

    rca32_acc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model_sum;
    logic        model_ovf;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        bus.start   = 1'b1;
        bus.cfg_len = len;
        model_sum   = '0;
        model_ovf   = 1'b0;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input int gap);
        logic [32:0] wide;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        wide = {1'b0, model_sum} + {1'b0, data};
        model_sum = wide[31:0];
        model_ovf = model_ovf | wide[32];
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic push_result();
        exp_q.push_back({model_ovf, model_sum});
    endtask

    // scoreboard: wait for a result, compare against the queue head, then handshake
    task automatic wait_result(input string name, input bit hold_start);
        int n;
        logic [32:0] exp;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%b required=1", name, bus.out_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_result out_sum=%h", name, bus.out_sum);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.out_sum !== exp[31:0]) begin
            errors++;
            $display("FAIL %s_sum got=%h required=%h", name, bus.out_sum, exp[31:0]);
        end
        checks++;
        if (bus.out_ovf !== exp[32]) begin
            errors++;
            $display("FAIL %s_ovf got=%b required=%b", name, bus.out_ovf, exp[32]);
        end
        bus.out_ready = 1'b1;
        if (hold_start) begin
            bus.start   = 1'b1;
            bus.cfg_len = 8'd5;
        end
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_to_idle busy=%b out_valid=%b required=0/0", name, bus.busy, bus.out_valid);
        end
        checks++;
        if (bus.out_sum !== exp[31:0]) begin
            errors++;
            $display("FAIL %s_idle_hold got=%h required=%h", name, bus.out_sum, exp[31:0]);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 || bus.out_ovf !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s v=%b sum=%h ovf=%b rdy=%b busy=%b st=%0d required 0/0/0/0/0/0",
                     name, bus.out_valid, bus.out_sum, bus.out_ovf, bus.in_ready, bus.busy, bus.dbg_state);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();
        check_reset_values("after_reset_release");
    endtask

    task automatic test_basic();
        do_start(8'd4);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready got=%b required=1", bus.in_ready);
        end
        for (int i = 1; i <= 3; i++) drive_beat(32'(i), 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got=%b required=0", bus.out_valid);
        end
        drive_beat(32'd4, 0);
        push_result();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got=%b required=1", bus.out_valid);
        end
        wait_result("basic", 1'b0);
    endtask

    task automatic test_wrap();
        do_start(8'd2);
        drive_beat(32'hFFFF_FFFF, 0);
        drive_beat(32'h0000_0002, 0);
        push_result();
        wait_result("wrap", 1'b0);
        do_start(8'd2);
        drive_beat(32'd3, 0);
        drive_beat(32'd4, 0);
        push_result();
        wait_result("ovf_cleared", 1'b0);
    endtask

    task automatic test_backpressure();
        do_start(8'd1);
        drive_beat(32'h1234_5678, 0);
        push_result();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h1234_5678 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d v=%b sum=%h rdy=%b required 1/12345678/0",
                         i, bus.out_valid, bus.out_sum, bus.in_ready);
            end
            tick();
        end
        wait_result("backpressure", 1'b0);
    endtask

    task automatic test_bubbles();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd100;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore rdy=%b busy=%b required 0/0", bus.in_ready, bus.busy);
        end
        bus.in_valid = 1'b0;
        do_start(8'd3);
        drive_beat(32'd5, 0);
        drive_beat(32'd7, 2);
        drive_beat(32'd9, 2);
        push_result();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1000;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_sum !== 32'h15) begin
            errors++;
            $display("FAIL done_ignore rdy=%b sum=%h required 0/00000015", bus.in_ready, bus.out_sum);
        end
        tick();
        bus.in_valid = 1'b0;
        wait_result("bubbles", 1'b0);
    endtask

    task automatic test_max_len();
        do_start(8'd0);
        for (int i = 0; i < 255; i++) drive_beat(32'd1, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_255 out_valid=%b required=0", bus.out_valid);
        end
        drive_beat(32'd1, 0);
        push_result();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_256 out_valid=%b required=1", bus.out_valid);
        end
        wait_result("maxlen", 1'b0);
    endtask

    task automatic test_reset_mid();
        do_start(8'd4);
        drive_beat(32'd3, 0);
        drive_beat(32'd5, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        #1;
        reset_n = 1'b1;
        tick();
        check_reset_values("reset_mid_after");
        do_start(8'd1);
        drive_beat(32'd7, 0);
        push_result();
        wait_result("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        int len;
        for (int b = 0; b < 4; b++) begin
            len = $urandom_range(1, 8);
            do_start(LEN_W'(len));
            for (int i = 0; i < len; i++) drive_beat($urandom, $urandom_range(0, 1));
            push_result();
            wait_result("random_block", 1'b1);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_sum     = '0;
        model_ovf     = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_max_len();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected count=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
